// File: rtl/pose_scorer_pkg.sv
// pose_scorer_pkg: FSM state type, width helpers and channel unpack shared by the pose scorer
package pose_scorer_pkg;

    typedef enum logic [1:0] {ACCUM, GRADE, SELECT} state_e;

    localparam int PACK_W = 1024;

    function automatic int cw_f(input int hres, input int vres);
        return $clog2(hres * vres + 1);
    endfunction

    function automatic int sw_f(input int hres, input int vres, input int pix_w);
        return cw_f(hres, vres) + pix_w;
    endfunction

    function automatic int grade_w_f(input int num_grades);
        return $clog2(num_grades);
    endfunction

    // Extracts channel c (w bits wide) from a packed vector with channel 0 in the LSBs
    function automatic logic [31:0] ch_dist(input logic [PACK_W-1:0] v, input int c, input int w);
        return 32'((v >> (c * w)) & ((PACK_W'(1) << w) - PACK_W'(1)));
    endfunction

endpackage

// File: rtl/scorer_grade_cmp.sv
// scorer_grade_cmp: per-channel distance accumulator and threshold-sweep grader (clamp under SCORER_CLAMP_EN)
module scorer_grade_cmp import pose_scorer_pkg::*; #(
    parameter int PIX_W      = 5,
    parameter int CW         = 16,
    parameter int SW         = 21,
    parameter int GW         = 3,
    parameter int NUM_GRADES = 8,
    parameter int DMAX       = 31
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             acc_i,
    input  logic             first_i,
    input  logic             skel_i,
    input  logic             start_i,
    input  logic             grade_i,
    input  logic             clr_i,
    input  logic [GW-1:0]    k_i,
    input  logic [CW-1:0]    count_i,
    input  logic [PIX_W-1:0] dist_i,
    output logic [GW-1:0]    g_o
);

    localparam int CMP_W = SW + GW + 1;

    logic [SW-1:0]    sum_q, sum_d;
    logic [GW-1:0]    g_q, g_d;
    logic [PIX_W-1:0] dist_e;
    logic             hit;

    // Accumulate skeleton distances and count threshold crossings; an empty frame passes every k since 0 >= 0
    always_comb begin
`ifdef SCORER_CLAMP_EN
        dist_e = dist_i > PIX_W'(DMAX) ? PIX_W'(DMAX) : dist_i;
`else
        dist_e = dist_i;
`endif
        hit = CMP_W'(sum_q) * CMP_W'(NUM_GRADES) >= CMP_W'(k_i) * CMP_W'(count_i) * CMP_W'(DMAX);
        sum_d = clr_i ? '0 : acc_i ? (first_i ? '0 : sum_q) + (skel_i ? SW'(dist_e) : '0) : sum_q;
        g_d = start_i ? '0 : grade_i ? g_q + GW'(hit) : g_q;
    end

    // Channel state registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sum_q <= '0;
            g_q   <= '0;
        end else begin
            sum_q <= sum_d;
            g_q   <= g_d;
        end
    end

    assign g_o = g_q;

endmodule

// File: rtl/pose_scorer_multi.sv
// pose_scorer_multi: grades a skeleton stream against NUM_CH reference poses; SCORER_CLAMP_EN clamps distances to DIST_CLAMP
module pose_scorer_multi import pose_scorer_pkg::*; #(
    parameter  int NUM_CH     = 4,
    parameter  int PIX_W      = 5,
    parameter  int HRES       = 320,
    parameter  int VRES       = 180,
    parameter  int NUM_GRADES = 8,
    parameter  int DIST_CLAMP = 15,
    localparam int CW         = cw_f(HRES, VRES),
    localparam int SW         = sw_f(HRES, VRES, PIX_W),
    localparam int GW         = grade_w_f(NUM_GRADES),
    localparam int BW         = $clog2(NUM_CH)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_in,
    input  logic                    first_pixel,
    input  logic                    last_pixel,
    input  logic                    skeleton_bit,
    input  logic [NUM_CH*PIX_W-1:0] pixel_distance,
    output logic                    busy,
    output logic                    valid_out,
    output logic [NUM_CH*GW-1:0]    grade,
    output logic [BW-1:0]           best_ch,
    output logic [GW-1:0]           best_grade,
    output logic                    no_skel,
    output logic                    drop_err
);

`ifdef SCORER_CLAMP_EN
    localparam int DMAX = DIST_CLAMP;
`else
    localparam int DMAX = (1 << PIX_W) - 1;
`endif

    if (DIST_CLAMP < 1 || DIST_CLAMP > (1 << PIX_W) - 1) begin : g_bad_clamp
        $error("DIST_CLAMP must lie in 1..2**PIX_W-1");
    end

    state_e               state_q, state_d;
    logic [GW-1:0]        k_q, k_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 acc, start, grade_en, clr;
    logic [GW-1:0]        g_w [NUM_CH];
    logic [NUM_CH*GW-1:0] g_pk;
    logic [BW-1:0]        bc;
    logic [GW-1:0]        bg;
    logic [NUM_CH*GW-1:0] res_grade_q, grade_q;
    logic [BW-1:0]        res_best_ch_q, best_ch_q;
    logic [GW-1:0]        res_best_grade_q, best_grade_q;
    logic                 res_no_skel_q, no_skel_q, pend_q, valid_q, drop_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        scorer_grade_cmp #(
            .PIX_W(PIX_W), .CW(CW), .SW(SW), .GW(GW), .NUM_GRADES(NUM_GRADES), .DMAX(DMAX)
        ) u_cmp (
            .clk_in  (clk_in),
            .rst_in  (rst_in),
            .acc_i   (acc),
            .first_i (first_pixel),
            .skel_i  (skeleton_bit),
            .start_i (start),
            .grade_i (grade_en),
            .clr_i   (clr),
            .k_i     (k_q),
            .count_i (cnt_q),
            .dist_i  (PIX_W'(ch_dist(PACK_W'(pixel_distance), c, PIX_W))),
            .g_o     (g_w[c])
        );
        assign g_pk[c*GW +: GW] = g_w[c];
    end

    // FSM state, threshold index and skeleton pixel count
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ACCUM;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a last beat starts the k sweep, the final k hands over to a one-cycle select
    always_comb begin
        state_d = state_q == ACCUM ? (start ? GRADE : ACCUM)
                : state_q == GRADE ? (k_q == GW'(NUM_GRADES - 1) ? SELECT : GRADE)
                : ACCUM;
        k_d     = start ? GW'(1) : state_q == GRADE ? k_q + GW'(1) : k_q;
        cnt_d   = clr ? '0 : acc ? (first_pixel ? '0 : cnt_q) + CW'(skeleton_bit) : cnt_q;
    end

    // FSM outputs: beats are accepted only in ACCUM
    always_comb begin
        busy     = state_q != ACCUM;
        acc      = valid_in && !busy;
        start    = acc && last_pixel;
        grade_en = state_q == GRADE;
        clr      = state_q == SELECT;
    end

    // Lowest grade wins; strict compare keeps the lowest index on ties
    always_comb begin
        bc = '0;
        bg = g_w[0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (g_w[i] < bg) begin
                bc = BW'(i);
                bg = g_w[i];
            end
        end
    end

    // Capture the result in SELECT, then publish it with the valid pulse one cycle later
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            res_grade_q      <= '0;
            res_best_ch_q    <= '0;
            res_best_grade_q <= '0;
            res_no_skel_q    <= 1'b0;
            pend_q           <= 1'b0;
            grade_q          <= '0;
            best_ch_q        <= '0;
            best_grade_q     <= '0;
            no_skel_q        <= 1'b0;
            valid_q          <= 1'b0;
            drop_q           <= 1'b0;
        end else begin
            if (clr) begin
                res_grade_q      <= g_pk;
                res_best_ch_q    <= bc;
                res_best_grade_q <= bg;
                res_no_skel_q    <= cnt_q == '0;
            end
            if (pend_q) begin
                grade_q      <= res_grade_q;
                best_ch_q    <= res_best_ch_q;
                best_grade_q <= res_best_grade_q;
                no_skel_q    <= res_no_skel_q;
            end
            pend_q  <= clr;
            valid_q <= pend_q;
            drop_q  <= drop_q | (valid_in & busy);
        end
    end

    assign valid_out  = valid_q;
    assign grade      = grade_q;
    assign best_ch    = best_ch_q;
    assign best_grade = best_grade_q;
    assign no_skel    = no_skel_q;
    assign drop_err   = drop_q;

endmodule

// File: tb/tb_pose_scorer_multi.sv
// tb_pose_scorer_multi: scoreboard bench for pose_scorer_multi with two channels
module tb_pose_scorer_multi;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       valid_in = 1'b0;
    logic       first_pixel = 1'b0;
    logic       last_pixel = 1'b0;
    logic       skeleton_bit = 1'b0;
    logic [9:0] pixel_distance = '0;
    logic       busy, valid_out, no_skel, drop_err;
    logic [5:0] grade;
    logic [0:0] best_ch;
    logic [2:0] best_grade;

    typedef struct {
        int g0;
        int g1;
        int bc;
        int bg;
        int ns;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   s0 = 0;
    int   s1 = 0;
    int   cnt = 0;
`ifdef SCORER_CLAMP_EN
    int   dmax = 15;
`else
    int   dmax = 31;
`endif

    pose_scorer_multi #(.NUM_CH(2), .PIX_W(5), .NUM_GRADES(8)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .first_pixel    (first_pixel),
        .last_pixel     (last_pixel),
        .skeleton_bit   (skeleton_bit),
        .pixel_distance (pixel_distance),
        .busy           (busy),
        .valid_out      (valid_out),
        .grade          (grade),
        .best_ch        (best_ch),
        .best_grade     (best_grade),
        .no_skel        (no_skel),
        .drop_err       (drop_err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cl(input int d);
        return d > dmax ? dmax : d;
    endfunction

    function automatic int mg(input int s, input int c);
        int r;
        if (c == 0) return 7;
        r = (s * 8) / (c * dmax);
        return r > 7 ? 7 : r;
    endfunction

    task automatic beat(input bit f, input bit l, input bit s, input int d0, input int d1);
        valid_in = 1'b1;
        first_pixel = f;
        last_pixel = l;
        skeleton_bit = s;
        pixel_distance = {5'(d1), 5'(d0)};
        if (f) begin
            s0 = 0;
            s1 = 0;
            cnt = 0;
        end
        if (s) begin
            cnt++;
            s0 += cl(d0);
            s1 += cl(d1);
        end
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        first_pixel = 1'b0;
        last_pixel = 1'b0;
        skeleton_bit = 1'b0;
    endtask

    task automatic push_exp();
        exp_t x;
        x.g0 = mg(s0, cnt);
        x.g1 = mg(s1, cnt);
        x.bc = x.g1 < x.g0 ? 1 : 0;
        x.bg = x.g1 < x.g0 ? x.g1 : x.g0;
        x.ns = cnt == 0 ? 1 : 0;
        x.cyc = cyc + 9;
        q.push_back(x);
    endtask

    task automatic frame(input int n, input int sm, input int d0, input int d1, input bit p);
        for (int i = 0; i < n; i++) begin
            beat(i == 0, i == n - 1,
                 sm == 2 ? 1'($urandom_range(0, 1)) : 1'(sm),
                 d0 < 0 ? int'($urandom_range(0, 31)) : d0,
                 d1 < 0 ? int'($urandom_range(0, 31)) : d1);
        end
        if (p) push_exp();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk_in);
        #1;
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid_out"}, valid_out, 0);
        chk({tag, "_grade"}, grade, 0);
        chk({tag, "_best_ch"}, best_ch, 0);
        chk({tag, "_best_grade"}, best_grade, 0);
        chk({tag, "_no_skel"}, no_skel, 0);
        chk({tag, "_drop_err"}, drop_err, 0);
    endtask

    always @(negedge clk_in) begin
        if (valid_out === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_valid", valid_out, 0);
            end else begin
                e = q.pop_front();
                chk("grade0", grade[2:0], e.g0);
                chk("grade1", grade[5:3], e.g1);
                chk("best_ch", best_ch, e.bc);
                chk("best_grade", best_grade, e.bg);
                chk("no_skel", no_skel, e.ns);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        chk_zero("reset");
        rst_in = 1'b0;
        frame(4, 1, 0, 31, 1);
        drain();
        frame(4, 1, 16, 8, 1);
        drain();
        frame(4, 1, 8, 8, 1);
        drain();
        frame(6, 0, 5, 5, 1);
        drain();
        frame(1, 1, 10, 3, 1);
        drain();
        frame(4, 1, 0, 31, 1);
        @(posedge clk_in);
        #1;
        chk("busy_grade", busy, 1);
        valid_in = 1'b1;
        first_pixel = 1'b1;
        last_pixel = 1'b1;
        skeleton_bit = 1'b1;
        pixel_distance = 10'h3ff;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        first_pixel = 1'b0;
        last_pixel = 1'b0;
        skeleton_bit = 1'b0;
        chk("drop_err_set", drop_err, 1);
        drain();
        beat(1, 0, 1, 31, 31);
        beat(0, 0, 1, 31, 31);
        frame(4, 1, 16, 8, 1);
        drain();
        chk("drop_err_sticky", drop_err, 1);
        frame(4, 1, 0, 31, 0);
        repeat (3) @(posedge clk_in);
        #1;
        chk("busy_before_rst", busy, 1);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk_zero("abort");
        repeat (12) @(posedge clk_in);
        #1;
        frame(4, 1, 16, 8, 1);
        drain();
        frame(4, 1, 31, 0, 1);
        drain();
        for (int i = 0; i < 4; i++) begin
            frame(int'($urandom_range(1, 12)), 2, -1, -1, 1);
            drain();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
